// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end with a small prefetch buffer. It walks the
// program counter sequentially and keeps one word request outstanding on
// the memory side. Responses are stored as {pc, instr} pairs in a circular
// buffer and handed to decode through a valid/ready handshake. A branch
// redirect flushes the buffer and restarts fetch at a new address. If the
// redirect arrives while a request is in flight, that request's response is
// thrown away.
//
// Optional build macro:
//   FETCH_QUEUE_BYPASS_EN - When the queue is empty and decode is ready, a
//                           memory response is forwarded combinationally to
//                           out_* in the same cycle as mem_ack. The response
//                           is not stored in the buffer. Without the macro
//                           there is no combinational path from mem_* to
//                           out_*.
//
// Parameters:
//   XLEN     - address/data width
//   DEPTH    - number of buffer entries (power of two, >= 2)
//   RESET_PC - first fetch address after reset
//   PC_STEP  - byte increment between sequential fetches
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   mem_req      out  fetch request, held until mem_ack
//   mem_addr     out  fetch address, stable while mem_req=1
//   mem_ack      in   response strobe, mem_rdata valid this cycle
//   mem_rdata    in   fetched instruction word
//   redirect     in   flush the buffer and restart fetch
//   redirect_pc  in   restart address (bits [1:0] ignored)
//   out_valid    out  head entry valid
//   out_ready    in   decode accepts the head entry
//   out_pc       out  head entry PC
//   out_instr    out  head entry instruction
// ---------------------------------------------------------------------------
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DISCARD
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q,    state_d;
   logic [CW-1:0]     count_q,    count_d;
   logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
   logic              mem_req_q,  mem_req_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;

   logic [XLEN-1:0]   pc_mem_q    [DEPTH];
   logic [XLEN-1:0]   instr_mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------
   logic            head_valid;
   logic            pop;
   logic            ack_ok;
   logic            bypass;
   logic            push;
   logic [CW-1:0]   count_nr;
   logic            space;
   logic [XLEN-1:0] redirect_pc_al;
   logic [XLEN-1:0] next_addr;

   assign head_valid = (count_q != '0);

   // A redirect flushes the buffer, so nothing may leave it that cycle.
   assign pop    = head_valid & out_ready & ~redirect;

   // Response for a live request (not one that is being discarded).
   assign ack_ok = (state_q == ST_WAIT) & mem_ack & ~redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
   // An empty buffer with decode ready: forward the response directly
   // instead of storing it and presenting it a cycle later.
   assign bypass = ack_ok & ~head_valid & out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push = ack_ok & ~bypass;

   // Occupancy after this cycle's pop/push. It decides whether a
   // back-to-back request can go out without overrunning the buffer.
   assign count_nr = count_q - CW'(pop) + CW'(push);
   assign space    = (count_nr < CW'(DEPTH));

   assign redirect_pc_al = redirect_pc & ~XLEN'(3);
   assign next_addr      = mem_addr_q + XLEN'(PC_STEP);

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fetch_pc_d = fetch_pc_q;

      if (redirect) begin
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fetch_pc_d = redirect_pc_al;
         unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_WAIT: begin
               if (mem_ack) begin
                  state_d   = ST_IDLE;
                  mem_req_d = 1'b0;
               end else begin
                  // The request must stay stable until it is acked, so
                  // keep it up and drop its response later.
                  state_d = ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (mem_ack) begin
                  state_d   = ST_IDLE;
                  mem_req_d = 1'b0;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         endcase
      end else begin
         count_d  = count_nr;
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
         unique case (state_q)
            ST_IDLE: begin
               if (count_q < CW'(DEPTH)) begin
                  state_d    = ST_WAIT;
                  mem_req_d  = 1'b1;
                  mem_addr_d = fetch_pc_q;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  fetch_pc_d = next_addr;
                  if (space) begin
                     mem_addr_d = next_addr;
                  end else begin
                     state_d   = ST_IDLE;
                     mem_req_d = 1'b0;
                  end
               end
            end
            ST_DISCARD: begin
               if (mem_ack) begin
                  state_d   = ST_IDLE;
                  mem_req_d = 1'b0;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Control registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // ------------------------------------------------------------------
   // Entry storage. It is cleared on reset so out_pc/out_instr read as
   // zero until the first entry lands.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= mem_addr_q;
         instr_mem_q[wr_ptr_q] <= mem_rdata;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign out_valid = head_valid | bypass;
   assign out_pc    = bypass ? mem_addr_q : pc_mem_q[rd_ptr_q];
   assign out_instr = bypass ? mem_rdata  : instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   int n_cmp  = 0;
   int n_fail = 0;

   // responder state
   bit resp_en, resp_rand, last_req, last_ack, req_new;
   int resp_delay, wait_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   fetch_queue #(
      .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // One clock cycle. Inputs are driven at the falling edge. The memory
   // responder acks a request after its chosen delay. Redirect is a pulse
   // that the caller raises after step() returns. Outputs are read 1 time
   // unit later.
   task automatic step();
      @(negedge clk);
      redirect = 1'b0;
      req_new  = mem_req && !(last_req && !last_ack);
      if (req_new)
         wait_cnt = resp_rand ? int'($urandom_range(0, 3)) : resp_delay;
      mem_ack = 1'b0;
      if (mem_req && resp_en) begin
         if (wait_cnt == 0) mem_ack = 1'b1;
         else               wait_cnt--;
      end
      mem_rdata = memf(mem_addr);
      last_req  = mem_req;
      last_ack  = mem_ack;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect = 1'b0; redirect_pc = '0;
      mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 0;
      last_req = 1'b0; last_ack = 1'b0; wait_cnt = 0; req_new = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      @(negedge clk); #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      n_cmp++; if (mem_addr !== RPC) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=%h", mem_addr, RPC); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
      n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
      @(negedge clk);
      rst_n = 1'b1;
      resp_en = 1'b0;
      step();
      n_cmp++; if (mem_req !== 1'b1 || mem_addr !== RPC) begin n_fail++; $display("FAIL reset_first_req got=%b/%h exp=1/%h", mem_req, mem_addr, RPC); end
      $display("test_reset done");
   endtask

   task automatic test_sequential();
      logic [31:0] addrs[$];
      logic [31:0] pcs[$];
      logic [31:0] ins[$];
      logic [31:0] exp_a, got_a, got_p, got_i;
      do_reset();
      out_ready = 1'b1; resp_delay = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (req_new) addrs.push_back(mem_addr);
         if (out_valid && out_ready) begin pcs.push_back(out_pc); ins.push_back(out_instr); end
      end
      for (int k = 0; k < 3; k++) begin
         exp_a = RPC + 32'(4 * k);
         got_a = (k < addrs.size()) ? addrs[k] : 32'hxxxx_xxxx;
         got_p = (k < pcs.size())   ? pcs[k]   : 32'hxxxx_xxxx;
         got_i = (k < ins.size())   ? ins[k]   : 32'hxxxx_xxxx;
         n_cmp++; if (got_a !== exp_a) begin n_fail++; $display("FAIL seq_req_addr[%0d] got=%h exp=%h", k, got_a, exp_a); end
         n_cmp++; if (got_p !== exp_a) begin n_fail++; $display("FAIL seq_out_pc[%0d] got=%h exp=%h", k, got_p, exp_a); end
         n_cmp++; if (got_i !== memf(exp_a)) begin n_fail++; $display("FAIL seq_out_instr[%0d] got=%h exp=%h", k, got_i, memf(exp_a)); end
      end
      $display("test_sequential done: %0d requests %0d pops", addrs.size(), pcs.size());
   endtask

   task automatic test_full();
      int  acks = 0;
      bit  seen = 1'b0;
      do_reset();
      out_ready = 1'b0; resp_delay = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (mem_ack) acks++;
      end
      n_cmp++; if (acks != DEPTH) begin n_fail++; $display("FAIL full_ack_count got=%0d exp=%0d", acks, DEPTH); end
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_mem_req got=%b exp=0", mem_req); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
      out_ready = 1'b1; #1;
      n_cmp++; if (out_pc !== RPC) begin n_fail++; $display("FAIL full_pop_pc got=%h exp=%h", out_pc, RPC); end
      step();
      out_ready = 1'b0; #1;
      n_cmp++; if (out_pc !== RPC + 32'h4) begin n_fail++; $display("FAIL full_next_head got=%h exp=%h", out_pc, RPC + 32'h4); end
      for (int i = 0; i < 4 && !seen; i++) begin
         step();
         if (req_new) begin
            seen = 1'b1;
            n_cmp++; if (mem_addr !== RPC + 32'h10) begin n_fail++; $display("FAIL full_restart_addr got=%h exp=%h", mem_addr, RPC + 32'h10); end
         end
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL full_restart_req got=none exp=request"); end
      $display("test_full done");
   endtask

   task automatic test_redirect_wait();
      bit seen = 1'b0;
      do_reset();
      out_ready = 1'b0; resp_delay = 0;
      step();                       // 0x100 acked immediately
      resp_delay = 3;
      step();                       // 0x104 issued, ack 3 cycles away
      redirect = 1'b1; redirect_pc = 32'h0000_2002; #1;
      n_cmp++; if (mem_addr !== 32'h104 || out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_setup got=%h/%b exp=104/1", mem_addr, out_valid); end
      resp_delay = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (req_new) begin
            seen = 1'b1;
            n_cmp++; if (mem_addr !== 32'h2000) begin n_fail++; $display("FAIL redir_new_addr got=%h exp=2000", mem_addr); end
         end else begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_valid[%0d] got=%b exp=0", i, out_valid); end
            if (mem_req) begin
               n_cmp++; if (mem_addr !== 32'h104) begin n_fail++; $display("FAIL redir_addr_hold[%0d] got=%h exp=104", i, mem_addr); end
            end
         end
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL redir_new_req got=none exp=request"); end
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         step();
         if (out_valid) begin
            seen = 1'b1;
            n_cmp++; if (out_pc !== 32'h2000 || out_instr !== memf(32'h2000)) begin n_fail++; $display("FAIL redir_first_out got=%h/%h exp=2000/%h", out_pc, out_instr, memf(32'h2000)); end
         end
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL redir_first_valid got=none exp=valid"); end
      $display("test_redirect_wait done");
   endtask

   task automatic test_redirect_ack();
      do_reset();
      out_ready = 1'b1; resp_en = 1'b0; resp_delay = 0;
      step();                       // request 0x100 pending
      resp_en = 1'b1;
      step();                       // ack this cycle
      redirect = 1'b1; redirect_pc = 32'h0000_3000; #1;
      n_cmp++; if (mem_ack !== 1'b1) begin n_fail++; $display("FAIL redack_setup got=%b exp=1", mem_ack); end
      step();
      n_cmp++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL redack_drop got=%b/%b exp=0/0", out_valid, mem_req); end
      step();
      n_cmp++; if (req_new !== 1'b1 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL redack_next_req got=%b/%h exp=1/3000", req_new, mem_addr); end
      $display("test_redirect_ack done");
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      do_reset();
      out_ready = 1'b0; resp_delay = 0;
      repeat (3) step();
      resp_en = 1'b0;
      step();                       // 0x10C outstanding, 3 entries held
      n_cmp++; if (mem_req !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup got=%b/%b exp=1/1", mem_req, out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got=%b/%b exp=0/0", mem_req, out_valid); end
      @(negedge clk);
      rst_n = 1'b1; resp_en = 1'b1; last_req = 1'b0; last_ack = 1'b0;
      for (int i = 0; i < 3 && !seen; i++) begin
         step();
         if (req_new) begin
            seen = 1'b1;
            n_cmp++; if (mem_addr !== RPC) begin n_fail++; $display("FAIL rstmid_restart got=%h exp=%h", mem_addr, RPC); end
         end
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_req got=none exp=request"); end
      $display("test_reset_mid done");
   endtask

   task automatic test_bypass();
      do_reset();
      out_ready = 1'b1; resp_en = 1'b0;
      step();                       // request 0x100 pending, queue empty
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
      #1;
      n_cmp++; if (out_valid !== BYP) begin n_fail++; $display("FAIL byp_ack_valid got=%b exp=%b", out_valid, BYP); end
      n_cmp++; if (out_instr !== (BYP ? 32'h13 : 32'h0)) begin n_fail++; $display("FAIL byp_ack_instr got=%h exp=%h", out_instr, BYP ? 32'h13 : 32'h0); end
      n_cmp++; if (out_pc !== (BYP ? RPC : 32'h0)) begin n_fail++; $display("FAIL byp_ack_pc got=%h exp=%h", out_pc, BYP ? RPC : 32'h0); end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      n_cmp++; if (out_valid !== !BYP) begin n_fail++; $display("FAIL byp_next_valid got=%b exp=%b", out_valid, !BYP); end
      n_cmp++; if (out_instr !== (BYP ? 32'h0 : 32'h13)) begin n_fail++; $display("FAIL byp_next_instr got=%h exp=%h", out_instr, BYP ? 32'h0 : 32'h13); end
      $display("test_bypass done (bypass=%0d)", BYP);
   endtask

   // Transaction-level reference: an ordered list of fetched words that
   // have not yet been consumed, plus the address the next fresh request
   // must carry.
   task automatic test_random();
      ent_t        q[$];
      ent_t        e;
      logic [31:0] exp_next, held, epc, ein;
      bit          dead = 1'b0, byp, ev;
      int          pops = 0;
      do_reset();
      resp_rand = 1'b1;
      exp_next = RPC; held = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         out_ready   = ($urandom_range(0, 9) < 7);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
         #1;
         if (req_new) begin
            n_cmp++; if (mem_addr !== exp_next) begin n_fail++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, exp_next); end
            n_cmp++; if (q.size() >= DEPTH) begin n_fail++; $display("FAIL rnd_req_when_full cyc=%0d got=%0d entries exp<%0d", cyc, q.size(), DEPTH); end
            held = mem_addr; dead = 1'b0;
         end else if (mem_req) begin
            n_cmp++; if (mem_addr !== held) begin n_fail++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, mem_addr, held); end
         end
         byp = BYP && q.size() == 0 && mem_req && mem_ack && !dead && out_ready && !redirect;
         ev  = (q.size() != 0) || byp;
         epc = byp ? mem_addr  : (q.size() != 0 ? q[0].pc    : 32'h0);
         ein = byp ? mem_rdata : (q.size() != 0 ? q[0].instr : 32'h0);
         n_cmp++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev); end
         if (ev) begin
            n_cmp++; if (out_pc !== epc || out_instr !== ein) begin n_fail++; $display("FAIL rnd_out_data cyc=%0d got=%h/%h exp=%h/%h", cyc, out_pc, out_instr, epc, ein); end
         end
         // advance the reference to the coming clock edge
         if (redirect) begin
            q.delete();
            exp_next = redirect_pc & 32'hFFFF_FFFC;
            dead = mem_req && !mem_ack;
         end else begin
            if (q.size() != 0 && out_ready) begin void'(q.pop_front()); pops++; end
            else if (byp) pops++;
            if (mem_req && mem_ack) begin
               if (dead) begin
                  dead = 1'b0;
               end else begin
                  exp_next = mem_addr + 32'h4;
                  if (!byp) begin
                     e.pc = mem_addr; e.instr = mem_rdata;
                     q.push_back(e);
                  end
               end
            end
         end
         if (q.size() > DEPTH) begin
            n_cmp++; n_fail++;
            $display("FAIL rnd_overflow cyc=%0d got=%0d entries exp<=%0d", cyc, q.size(), DEPTH);
            void'(q.pop_front());
         end
      end
      n_cmp++; if (pops < 200) begin n_fail++; $display("FAIL rnd_progress got=%0d pops exp>=200", pops); end
      $display("test_random done: %0d pops", pops);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
